barker_symbol_sequencer: RTL and testbench
==========================================

// Module: barker_symbol_sequencer
// PURPOSE
//  Symbol/chip timing controller for the 802.11b despreader. Sequences the 11-chip Barker
//  window from the sample strobe. Acquires symbol phase from the correlator peak, then
//  tracks it with +/-1-sample early/late correction. Issues chip_strobe, sym_strobe and the
//  chip index to the despreader/demod; flags lock loss and strobe overrun.
// PARAMETERS
//  CHIPS_PER_SYM  11  chips per Barker symbol
//  SAMPS_PER_CHIP 2   input samples per chip (>=2)
//  MISS_MAX       4   consecutive missed peaks before dropping lock (1..15)
// PORTS
//  clk        in   1  system clock (only clock)
//  reset      in   1  synchronous, active-high
//  enable     in   1  run sequencer; 0 forces IDLE
//  strobe_in  in   1  sample strobe, single-cycle pulse
//  peak_in    in   1  correlator peak; valid only with strobe_in
//  clr_ovr    in   1  clears sticky overrun
//  chip_strobe out 1  1-cycle pulse, last sample of each chip
//  sym_strobe out  1  1-cycle pulse, each symbol boundary
//  chip_idx   out  4  chip index 0..CHIPS_PER_SYM-1 of current sample
//  locked     out  1  high in TRACK
//  overrun    out  1  sticky: strobe_in high on two consecutive clk cycles
//  state      out  2  0 IDLE, 1 SEARCH, 2 TRACK
// BEHAVIOUR
//  - Reset: all outputs 0, state=IDLE, samp_cnt=0, miss_cnt=0, win_hit=0.
//  - All outputs registered; a pulse appears the cycle after the causing strobe_in.
//  - SYM_LEN = CHIPS_PER_SYM*SAMPS_PER_CHIP (22). samp_cnt counts 0..SYM_LEN-1, advancing
//    only on strobe_in.
//  - chip_idx = samp_cnt/SAMPS_PER_CHIP. Use a sub-counter; no divider.
//  - chip_strobe when samp_cnt%SAMPS_PER_CHIP==SAMPS_PER_CHIP-1, in TRACK only.
//  - IDLE: enable=1 -> SEARCH next cycle. Counters held at 0.
//  - SEARCH: strobe_in&peak_in -> samp_cnt<=0, sym_strobe, miss_cnt<=0, TRACK.
//  - TRACK: nominal wrap SYM_LEN-1 -> 0 asserts sym_strobe.
//    Peak window = samp_cnt in {SYM_LEN-2, SYM_LEN-1, 0}.
//    Peak at SYM_LEN-1: on time; nominal wrap.
//    Peak at SYM_LEN-2 (early): next samp_cnt<=0, sym_strobe now (symbol shortened by 1).
//    Peak at 0 (late): samp_cnt held at 0 for one more strobe (lengthened by 1).
//      No extra sym_strobe.
//    Only the first peak in a window adjusts timing and sets win_hit; later peaks are ignored.
//    Peaks outside the window are ignored.
//    Window close = strobe at samp_cnt==0 that is not a late hold:
//      win_hit=0 -> miss_cnt++; else miss_cnt<=0. Then win_hit<=0.
//    miss_cnt reaching MISS_MAX -> SEARCH, locked<=0, samp_cnt<=0.
//  - enable=0 in any state -> IDLE next cycle, counters cleared. Wins over a simultaneous peak.
//  - Reset mid-symbol: same as reset. No pulses in the reset cycle or the cycle after.
//  - overrun: set when strobe_in is high in cycle n and n-1. Held until clr_ovr or reset.
//    Set wins over a simultaneous clr_ovr. The second strobe is still counted.
//  - Widths: samp_cnt 5b (SYM_LEN<=32, checked at elaboration). miss_cnt 4b.
//    All compares unsigned.
// STRUCTURE
//  - Shared package: state encodings (ST_IDLE/ST_SEARCH/ST_TRACK) and the SYM_LEN
//    function. The same package serves the despreader.
//  - One sub-module, sym_phase_counter: samp_cnt + chip sub-counter with load-zero and
//    hold controls; outputs samp_cnt, chip_idx, chip_last.
//  - The FSM, window/miss logic and overrun flag stay in the top level.
// TESTING (SAMPS_PER_CHIP=2, CHIPS_PER_SYM=11, MISS_MAX=4, strobe every 4 clks)
//  1. Acquire: enable; peak on strobe #5 -> TRACK, sym_strobe 1 clk later.
//     Then peaks every 22 strobes -> sym_strobe every 88 clks, 11 chip_strobes per symbol,
//     miss_cnt=0.
//  2. Early/late: peak 21 strobes after last -> sym_strobe at 21. Next peak 23 strobes
//     later -> count held, one sym_strobe only. locked stays 1 throughout.
//  3. Lock loss: stop peaks -> state=SEARCH, locked=0 on the 4th window close
//     (~4*22 strobes). Resume peaks -> reacquire.
//  4. Overrun: strobe_in high 2 consecutive clks -> overrun=1 and stays 1.
//     clr_ovr same cycle as a new double strobe -> stays 1. Lone clr_ovr -> 0.
//  5. Interrupts: enable=0 with a simultaneous peak in TRACK -> IDLE, no sym_strobe.
//     Reset mid-symbol -> all outputs 0 next cycle.
//  6. Double peak: peaks at samp_cnt 20 and 21 -> only the early adjust applied,
//     one sym_strobe.

Source files
------------

// File: rtl/barker_symbol_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : barker_symbol_sequencer_pkg
// Description : Shared definitions for the Barker symbol sequencer and the
//               despreader: state encodings, counter widths and the symbol
//               length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package barker_symbol_sequencer_pkg;

    // Sequencer state encodings (also exported on the state port)
    localparam int         c_state_w = 2;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_TRACK  = 2'd2;

    // Counter widths
    localparam int c_samp_w = 5;   // sample-in-symbol counter, SYM_LEN <= 32
    localparam int c_chip_w = 4;   // chip index
    localparam int c_miss_w = 4;   // consecutive missed-peak counter

    // Samples per Barker symbol
    function automatic int sym_len(input int chips, input int samps_per_chip);
        return chips * samps_per_chip;
    endfunction

endpackage
`default_nettype wire

// File: rtl/barker_symbol_sequencer_sym_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : sym_phase_counter
// Description : Sample-in-symbol counter with a chip sub-counter, so the chip
//               index is produced without a divider. Supports a synchronous
//               load-to-zero and a one-strobe hold.
// Revision    : 1.0 - initial release
// ============================================================================
module sym_phase_counter
    import barker_symbol_sequencer_pkg::*;
#(
    parameter int CHIPS_PER_SYM  = 11,
    parameter int SAMPS_PER_CHIP = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clear,    // load zero, dominates everything
    input  logic                i_advance,  // sample strobe
    input  logic                i_hold,     // swallow this strobe
    output logic [c_samp_w-1:0] o_samp_cnt,
    output logic [c_chip_w-1:0] o_chip_idx,
    output logic                o_chip_last
);

    localparam int                  c_sym_len   = sym_len(CHIPS_PER_SYM, SAMPS_PER_CHIP);
    localparam logic [c_samp_w-1:0] c_samp_last = c_samp_w'(c_sym_len - 1);
    localparam logic [c_samp_w-1:0] c_sub_last  = c_samp_w'(SAMPS_PER_CHIP - 1);

    logic [c_samp_w-1:0] r_samp_cnt;
    logic [c_samp_w-1:0] r_sub_cnt;
    logic [c_chip_w-1:0] r_chip_idx;

    // Advance sample/chip position on each accepted strobe, wrapping per symbol
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_samp_cnt <= '0;
            r_sub_cnt  <= '0;
            r_chip_idx <= '0;
        end else if (i_advance && !i_hold) begin
            if (r_samp_cnt == c_samp_last) begin
                r_samp_cnt <= '0;
                r_sub_cnt  <= '0;
                r_chip_idx <= '0;
            end else begin
                r_samp_cnt <= r_samp_cnt + 1'b1;
                if (r_sub_cnt == c_sub_last) begin
                    r_sub_cnt  <= '0;
                    r_chip_idx <= r_chip_idx + 1'b1;
                end else begin
                    r_sub_cnt  <= r_sub_cnt + 1'b1;
                end
            end
        end
    end

    assign o_samp_cnt  = r_samp_cnt;
    assign o_chip_idx  = r_chip_idx;
    assign o_chip_last = (r_sub_cnt == c_sub_last);

endmodule
`default_nettype wire

// File: rtl/barker_symbol_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : barker_symbol_sequencer
// Description : Symbol/chip timing controller for the 802.11b despreader.
//               Acquires symbol phase from the correlator peak, tracks it with
//               +/-1-sample early/late correction, and flags lock loss and
//               sample strobe overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module barker_symbol_sequencer
    import barker_symbol_sequencer_pkg::*;
#(
    parameter int CHIPS_PER_SYM  = 11,
    parameter int SAMPS_PER_CHIP = 2,
    parameter int MISS_MAX       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       strobe_in,
    input  logic       peak_in,
    input  logic       clr_ovr,
    output logic       chip_strobe,
    output logic       sym_strobe,
    output logic [3:0] chip_idx,
    output logic       locked,
    output logic       overrun,
    output logic [1:0] state
);

    localparam int                  c_sym_len   = sym_len(CHIPS_PER_SYM, SAMPS_PER_CHIP);
    localparam logic [c_samp_w-1:0] c_samp_last = c_samp_w'(c_sym_len - 1);
    localparam logic [c_samp_w-1:0] c_samp_early = c_samp_w'(c_sym_len - 2);
    localparam logic [c_miss_w-1:0] c_miss_max  = c_miss_w'(MISS_MAX);

    if (c_sym_len > 32 || SAMPS_PER_CHIP < 2 || MISS_MAX < 1 || MISS_MAX > 15) begin : g_param_check
        $error("barker_symbol_sequencer: unsupported parameter combination");
    end

    logic [c_state_w-1:0] r_state;
    logic [c_miss_w-1:0]  r_miss_cnt;
    logic                 r_win_hit;
    logic                 r_strobe_d;
    logic                 r_overrun;
    logic                 r_chip_strobe;
    logic                 r_sym_strobe;
    logic                 r_locked;

    logic [c_state_w-1:0] w_state_nxt;
    logic [c_miss_w-1:0]  w_miss_nxt;
    logic [c_miss_w-1:0]  w_miss_inc;
    logic                 w_win_hit_nxt;
    logic                 w_sym_pulse;
    logic                 w_chip_pulse;
    logic                 w_cnt_clear;
    logic                 w_cnt_hold;
    logic [c_samp_w-1:0]  w_samp_cnt;
    logic [c_chip_w-1:0]  w_chip_idx;
    logic                 w_chip_last;
    logic                 w_peak;
    logic                 w_in_win;
    logic                 w_first;
    logic                 w_early;
    logic                 w_late;
    logic                 w_close;
    logic                 w_wrap;

    sym_phase_counter #(
        .CHIPS_PER_SYM  (CHIPS_PER_SYM),
        .SAMPS_PER_CHIP (SAMPS_PER_CHIP)
    ) u_phase (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_cnt_clear),
        .i_advance   (strobe_in),
        .i_hold      (w_cnt_hold),
        .o_samp_cnt  (w_samp_cnt),
        .o_chip_idx  (w_chip_idx),
        .o_chip_last (w_chip_last)
    );

    // Peak window spans the last two samples of a symbol and the first of the next
    assign w_peak     = strobe_in && peak_in;
    assign w_in_win   = (w_samp_cnt == c_samp_early) || (w_samp_cnt == c_samp_last) ||
                        (w_samp_cnt == '0);
    assign w_first    = w_peak && w_in_win && !r_win_hit;
    assign w_early    = w_first && (w_samp_cnt == c_samp_early);
    assign w_late     = w_first && (w_samp_cnt == '0);
    // A late peak holds the count at zero; the following strobe closes the window
    assign w_close    = strobe_in && (w_samp_cnt == '0) && !w_late;
    assign w_wrap     = strobe_in && (w_samp_cnt == c_samp_last);
    assign w_miss_inc = r_miss_cnt + 1'b1;

    // Next-state, window bookkeeping and pulse decode
    always_comb begin
        w_state_nxt   = r_state;
        w_miss_nxt    = r_miss_cnt;
        w_win_hit_nxt = r_win_hit;
        w_sym_pulse   = 1'b0;
        w_chip_pulse  = 1'b0;
        w_cnt_clear   = 1'b1;
        w_cnt_hold    = 1'b0;
        if (!enable) begin
            w_state_nxt   = ST_IDLE;
            w_miss_nxt    = '0;
            w_win_hit_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (w_peak) begin
                        // The acquiring peak counts as the hit for its own window
                        w_state_nxt   = ST_TRACK;
                        w_sym_pulse   = 1'b1;
                        w_miss_nxt    = '0;
                        w_win_hit_nxt = 1'b1;
                    end
                end
                ST_TRACK: begin
                    w_cnt_clear  = w_early;
                    w_cnt_hold   = w_late;
                    w_chip_pulse = strobe_in && w_chip_last;
                    w_sym_pulse  = w_early || w_wrap;
                    if (w_first) begin
                        w_win_hit_nxt = 1'b1;
                    end
                    if (w_close) begin
                        w_win_hit_nxt = 1'b0;
                        if (r_win_hit) begin
                            w_miss_nxt = '0;
                        end else if (w_miss_inc >= c_miss_max) begin
                            w_state_nxt = ST_SEARCH;
                            w_miss_nxt  = '0;
                            w_cnt_clear = 1'b1;
                        end else begin
                            w_miss_nxt = w_miss_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_miss_cnt    <= '0;
            r_win_hit     <= 1'b0;
            r_chip_strobe <= 1'b0;
            r_sym_strobe  <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_miss_cnt    <= w_miss_nxt;
            r_win_hit     <= w_win_hit_nxt;
            r_chip_strobe <= w_chip_pulse;
            r_sym_strobe  <= w_sym_pulse;
            r_locked      <= (w_state_nxt == ST_TRACK);
        end
    end

    // Sticky overrun: back-to-back strobes; setting wins over clearing
    always_ff @(posedge clk) begin
        if (reset) begin
            r_strobe_d <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_strobe_d <= strobe_in;
            if (strobe_in && r_strobe_d) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign chip_strobe = r_chip_strobe;
    assign sym_strobe  = r_sym_strobe;
    assign chip_idx    = w_chip_idx;
    assign locked      = r_locked;
    assign overrun     = r_overrun;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_barker_symbol_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_barker_symbol_sequencer
// Description : Directed bench for barker_symbol_sequencer: vector table for
//               acquire/track/early/late/lock-loss, hand sequences for
//               interrupts, reset and overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barker_symbol_sequencer;
    import barker_symbol_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       strobe_in;
    logic       peak_in;
    logic       clr_ovr;
    logic       chip_strobe;
    logic       sym_strobe;
    logic [3:0] chip_idx;
    logic       locked;
    logic       overrun;
    logic [1:0] state;

    int n_cmp = 0;
    int n_err = 0;
    int tot_sym = 0;
    int tot_chip = 0;

    barker_symbol_sequencer #(
        .CHIPS_PER_SYM  (11),
        .SAMPS_PER_CHIP (2),
        .MISS_MAX       (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .strobe_in   (strobe_in),
        .peak_in     (peak_in),
        .clr_ovr     (clr_ovr),
        .chip_strobe (chip_strobe),
        .sym_strobe  (sym_strobe),
        .chip_idx    (chip_idx),
        .locked      (locked),
        .overrun     (overrun),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Pulse tallies, sampled mid-cycle
    always @(negedge clk) begin
        if (sym_strobe)  tot_sym  <= tot_sym + 1;
        if (chip_strobe) tot_chip <= tot_chip + 1;
    end

    typedef struct {
        int         gap;        // plain strobes before the final strobe
        bit         pk;         // peak on the final strobe
        int         exp_sym;    // sym_strobes over the record
        int         exp_chip;   // chip_strobes over the record
        bit         exp_now;    // sym_strobe right after the final strobe
        logic [1:0] exp_state;
        bit         exp_locked;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobe every 4 clocks; reports sym_strobe in the cycle after it
    task automatic do_strobe(input bit pk, output bit sym_now);
        strobe_in = 1'b1;
        peak_in   = pk;
        tick();
        strobe_in = 1'b0;
        peak_in   = 1'b0;
        sym_now   = sym_strobe;
        repeat (3) tick();
    endtask

    initial begin
        bit now;
        int s0, c0;

        vecs[0]  = '{4,  1'b1, 1, 0,  1'b1, ST_TRACK,  1'b1}; // acquire on strobe #5
        vecs[1]  = '{21, 1'b1, 1, 11, 1'b1, ST_TRACK,  1'b1}; // on time
        vecs[2]  = '{21, 1'b1, 1, 11, 1'b1, ST_TRACK,  1'b1}; // on time
        vecs[3]  = '{20, 1'b1, 1, 10, 1'b1, ST_TRACK,  1'b1}; // early: 21 strobes
        vecs[4]  = '{22, 1'b1, 1, 11, 1'b0, ST_TRACK,  1'b1}; // late: 23 strobes, hold
        vecs[5]  = '{21, 1'b1, 1, 11, 1'b1, ST_TRACK,  1'b1}; // on time after hold
        vecs[6]  = '{20, 1'b1, 1, 10, 1'b1, ST_TRACK,  1'b1}; // double peak: first at 20
        vecs[7]  = '{0,  1'b1, 0, 0,  1'b0, ST_TRACK,  1'b1}; // second at next strobe ignored
        vecs[8]  = '{20, 1'b1, 1, 11, 1'b1, ST_TRACK,  1'b1}; // phase unchanged by 2nd peak
        vecs[9]  = '{87, 1'b0, 4, 44, 1'b1, ST_TRACK,  1'b1}; // three misses, still locked
        vecs[10] = '{0,  1'b0, 0, 0,  1'b0, ST_SEARCH, 1'b0}; // fourth miss drops lock
        vecs[11] = '{3,  1'b1, 1, 0,  1'b1, ST_TRACK,  1'b1}; // reacquire
        vecs[12] = '{21, 1'b1, 1, 11, 1'b1, ST_TRACK,  1'b1};

        reset = 1'b1; enable = 1'b0; strobe_in = 1'b0; peak_in = 1'b0; clr_ovr = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_chip_strobe", int'(chip_strobe), 0);
        check("rst_sym_strobe",  int'(sym_strobe),  0);
        check("rst_chip_idx",    int'(chip_idx),    0);
        check("rst_locked",      int'(locked),      0);
        check("rst_overrun",     int'(overrun),     0);
        check("rst_state",       int'(state),       int'(ST_IDLE));

        reset = 1'b0;
        tick();
        check("idle_hold", int'(state), int'(ST_IDLE));
        enable = 1'b1;
        tick();
        check("enable_search", int'(state), int'(ST_SEARCH));

        // Table-driven acquisition and tracking
        for (int i = 0; i < 13; i++) begin
            s0 = tot_sym;
            c0 = tot_chip;
            for (int k = 0; k < vecs[i].gap; k++) do_strobe(1'b0, now);
            do_strobe(vecs[i].pk, now);
            check($sformatf("v%0d_sym_cnt", i),  tot_sym - s0,     vecs[i].exp_sym);
            check($sformatf("v%0d_chip_cnt", i), tot_chip - c0,    vecs[i].exp_chip);
            check($sformatf("v%0d_sym_now", i),  int'(now),        int'(vecs[i].exp_now));
            check($sformatf("v%0d_state", i),    int'(state),      int'(vecs[i].exp_state));
            check($sformatf("v%0d_locked", i),   int'(locked),     int'(vecs[i].exp_locked));
        end
        check("no_overrun_spaced", int'(overrun), 0);

        // Chip index mid-symbol
        repeat (5) do_strobe(1'b0, now);
        check("chip_idx_samp5", int'(chip_idx), 2);

        // enable=0 together with an early peak: IDLE wins, no sym_strobe
        repeat (15) do_strobe(1'b0, now);
        check("chip_idx_samp20", int'(chip_idx), 10);
        enable = 1'b0; strobe_in = 1'b1; peak_in = 1'b1;
        tick();
        strobe_in = 1'b0; peak_in = 1'b0;
        check("dis_sym_strobe", int'(sym_strobe), 0);
        check("dis_state",      int'(state),      int'(ST_IDLE));
        check("dis_locked",     int'(locked),     0);
        check("dis_chip_idx",   int'(chip_idx),   0);
        tick();
        check("dis_sym_later",  int'(sym_strobe), 0);

        // Reacquire, then reset mid-symbol on a chip-boundary strobe
        enable = 1'b1;
        tick();
        do_strobe(1'b1, now);
        check("reacq_state", int'(state), int'(ST_TRACK));
        repeat (3) do_strobe(1'b0, now);
        check("pre_rst_chip_idx", int'(chip_idx), 1);
        reset = 1'b1; strobe_in = 1'b1; peak_in = 1'b0;
        tick();
        reset = 1'b0; strobe_in = 1'b0;
        check("mid_rst_chip_strobe", int'(chip_strobe), 0);
        check("mid_rst_sym_strobe",  int'(sym_strobe),  0);
        check("mid_rst_chip_idx",    int'(chip_idx),    0);
        check("mid_rst_locked",      int'(locked),      0);
        check("mid_rst_overrun",     int'(overrun),     0);
        check("mid_rst_state",       int'(state),       int'(ST_IDLE));
        tick();
        check("post_rst_chip_strobe", int'(chip_strobe), 0);
        check("post_rst_sym_strobe",  int'(sym_strobe),  0);
        check("post_rst_state",       int'(state),       int'(ST_SEARCH));

        // Overrun: double strobe sets, second strobe still counted
        do_strobe(1'b1, now);
        check("ovr_acq_state", int'(state), int'(ST_TRACK));
        strobe_in = 1'b1;
        tick();
        check("ovr_single", int'(overrun), 0);
        tick();
        strobe_in = 1'b0;
        check("ovr_set", int'(overrun), 1);
        repeat (6) tick();
        check("ovr_sticky", int'(overrun), 1);
        check("ovr_counted", int'(chip_idx), 1);
        // Set wins over simultaneous clear
        strobe_in = 1'b1;
        tick();
        clr_ovr = 1'b1;
        tick();
        strobe_in = 1'b0; clr_ovr = 1'b0;
        check("ovr_set_wins", int'(overrun), 1);
        check("ovr_counted2", int'(chip_idx), 2);
        repeat (2) tick();
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("ovr_cleared", int'(overrun), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
